spi_shift_engine: RTL and testbench

Parametrised SPI master shift engine for the SPI_APB peripheral. It serialises one `DATA_WIDTH`-bit word per transaction and supports all four CPOL/CPHA modes, MSB- or LSB-first bit order and a programmable SCLK divider. It drives one of `NUM_SS` active-low slave selects. It sits between the APB register file, which supplies the configuration and the start pulse and reads `rx_data`, and the SPI pins.

---
 rtl/spi_shift_engine.sv | 202 ++++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master shift engine for the SPI_APB peripheral.
// One DATA_WIDTH-bit word per transaction, all four CPOL/CPHA modes,
// MSB/LSB-first order, programmable SCLK half-period of clk_div+1 pclk cycles.
// Optional feature macro: SPI_SHIFT_LOOPBACK_EN adds a 'loopback' input that
// feeds the sampler from the internal mosi and keeps ss_n deasserted.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SS     = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [SS_W-1:0]       ss_sel,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n,
  output logic [1:0]            state_dbg
);

  // Handshake: start is a request that is taken only while busy is low (IDLE);
  // a start seen while busy is dropped, not queued. done pulses for one cycle
  // with busy already low, and a start in that same cycle is accepted.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int ECNT_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_WIDTH);
  localparam logic [ECNT_W-1:0] FIRST_EDGE = ECNT_W'(1);

  logic [1:0]            state;
  logic [DIV_WIDTH-1:0]  hcnt;
  logic [ECNT_W-1:0]     ecnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  cpol_q, cpha_q, lsb_q;
  logic                  busy_q, done_q, sclk_q, mosi_q;
  logic [NUM_SS-1:0]     ss_q;
  logic                  lb_q;

  logic                  half_end, last_half, tgl, leading;
  logic                  do_sample, do_shift, fin, rx_bit;
  logic [ECNT_W-1:0]     edge_t;
  logic [NUM_SS-1:0]     ss_dec;

  assign half_end  = (hcnt == div_q);
  assign last_half = (ecnt == LAST_EDGE);
  assign edge_t    = ecnt + 1'b1;
  assign leading   = edge_t[0];

  // SCLK toggles at the end of SETUP and of every XFER half-period but the last.
  always_comb begin
    tgl = 1'b0;
    if (state == S_SETUP)     tgl = half_end;
    else if (state == S_XFER) tgl = half_end && !last_half;
  end

  // CPHA=0 samples on leading edges and shifts on trailing ones (not the final);
  // CPHA=1 shifts on leading edges (the first just keeps the preloaded bit).
  always_comb begin
    do_sample = tgl && (cpha_q ? !leading : leading);
    do_shift  = tgl && (cpha_q ? (leading && (edge_t != FIRST_EDGE))
                               : (!leading && (edge_t != LAST_EDGE)));
    fin = ((state == S_XFER) && half_end && last_half && (div_q == '0)) ||
          ((state == S_HOLD) && half_end);
  end

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = lb_q ? mosi_q : miso;
`else
  assign rx_bit = miso;
  assign lb_q   = 1'b0;
`endif

  // Decode the slave index; out-of-range indices and loopback select nobody.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
    end
`ifdef SPI_SHIFT_LOOPBACK_EN
    if (loopback) ss_dec = '1;
`endif
  end

  // Main sequencer: IDLE -> SETUP -> XFER -> HOLD -> IDLE, plus shift datapath.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state  <= S_IDLE;
      hcnt   <= '0;
      ecnt   <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      rx_q   <= '0;
      div_q  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      ss_q   <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          sclk_q <= cpol;
          if (start) begin
            state  <= S_SETUP;
            hcnt   <= '0;
            ecnt   <= '0;
            busy_q <= 1'b1;
            ss_q   <= ss_dec;
            tx_sr  <= tx_data;
            mosi_q <= lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            div_q  <= clk_div;
          end
        end
        S_SETUP: begin
          hcnt <= half_end ? '0 : hcnt + 1'b1;
          if (half_end) state <= S_XFER;
        end
        S_XFER: begin
          hcnt <= half_end ? '0 : hcnt + 1'b1;
          if (half_end && last_half) begin
            state <= S_HOLD;
            hcnt  <= DIV_WIDTH'(1);
          end
        end
        S_HOLD: hcnt <= hcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
      if (tgl) begin
        sclk_q <= ~sclk_q;
        ecnt   <= edge_t;
      end
      if (do_shift) begin
        if (lsb_q) begin
          tx_sr  <= tx_sr >> 1;
          mosi_q <= tx_sr[1];
        end else begin
          tx_sr  <= tx_sr << 1;
          mosi_q <= tx_sr[DATA_WIDTH-2];
        end
      end
      if (do_sample) begin
        if (lsb_q) rx_sr <= {rx_bit, rx_sr[DATA_WIDTH-1:1]};
        else       rx_sr <= {rx_sr[DATA_WIDTH-2:0], rx_bit};
      end
      if (fin) begin
        state  <= S_IDLE;
        hcnt   <= '0;
        ecnt   <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        ss_q   <= '1;
        mosi_q <= 1'b0;
        sclk_q <= cpol_q;
        rx_q   <= rx_sr;
      end
    end
  end

`ifdef SPI_SHIFT_LOOPBACK_EN
  // Loopback select is captured with the rest of the transaction mode.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                      lb_q <= 1'b0;
    else if ((state == S_IDLE) && start) lb_q <= loopback;
  end
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_data   = rx_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss_n      = ss_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed bench for spi_shift_engine with a table of
// transaction vectors, an SPI slave model, a done-pulse scoreboard and
// hand-written sequences for busy/back-to-back, mid-transfer reset and NUM_SS=3.
module tb_spi_shift_engine;

  // ---------------- clock / reset / signals ----------------
  logic       pclk = 1'b0;
  logic       preset_n, start, start3;
  logic [7:0] tx_data, clk_div;
  logic       cpol, cpha, lsb_first, miso;
  logic [1:0] ss_sel;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic       loopback;
`endif
  logic       busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [3:0] ss_n;
  logic [1:0] state_dbg;
  logic       busy3, done3, sclk3, mosi3;
  logic [7:0] rx3;
  logic [2:0] ss3;
  logic [1:0] state3;

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  spi_shift_engine #(.DATA_WIDTH(8), .NUM_SS(4), .DIV_WIDTH(8)) dut (
    .pclk(pclk), .preset_n(preset_n), .start(start), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .ss_sel(ss_sel),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(loopback),
`endif
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n), .state_dbg(state_dbg)
  );

  spi_shift_engine #(.DATA_WIDTH(8), .NUM_SS(3), .DIV_WIDTH(8)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .start(start3), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .ss_sel(ss_sel),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(loopback),
`endif
    .busy(busy3), .done(done3), .rx_data(rx3), .sclk(sclk3), .mosi(mosi3),
    .miso(miso), .ss_n(ss3), .state_dbg(state3)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model (configured by the test, state owned here) ----------------
  logic       sl_active = 1'b0, sl_cpha = 1'b0, sl_lsb = 1'b0, sl_idle_miso = 1'b0;
  logic [7:0] sl_data = 8'h00;
  int         sl_gap = 1, sl_t0 = 0, sl_gen = 0;
  int         s_gen = 0, s_edges = 0, s_first_edge = -1, s_last = 0, s_bad_gap = 0;
  int         s_tx_idx = 0, s_rx_idx = 0;
  logic [7:0] s_rx = 8'h00;
  logic       s_first_bit = 1'b0, s_prev = 1'b0;

  function automatic logic sbit(input logic [7:0] d, input logic lsb, input int k);
    return lsb ? d[k] : d[7-k];
  endfunction

  task automatic slave_sample();
    if (s_rx_idx < 8) begin
      if (s_rx_idx == 0) s_first_bit = mosi;
      s_rx[sl_lsb ? s_rx_idx : 7 - s_rx_idx] = mosi;
      s_rx_idx++;
    end
  endtask

  // Reacts shortly after each pclk edge to SCLK changes, as an SPI slave would.
  always @(posedge pclk) begin
    #1;
    if (sl_gen != s_gen) begin
      s_gen = sl_gen; s_edges = 0; s_first_edge = -1; s_bad_gap = 0;
      s_tx_idx = 0; s_rx_idx = 0; s_rx = 8'h00;
      if (!sl_cpha) miso = sbit(sl_data, sl_lsb, 0);
    end else if (!sl_active) begin
      miso = sl_idle_miso;
    end else if (sclk !== s_prev) begin
      s_edges++;
      if (s_edges == 1) s_first_edge = cyc - sl_t0;
      else if (cyc - s_last != sl_gap) s_bad_gap++;
      s_last = cyc;
      if (s_edges % 2 == 1) begin
        if (sl_cpha) begin
          if (s_tx_idx < 8) miso = sbit(sl_data, sl_lsb, s_tx_idx);
          s_tx_idx++;
        end else slave_sample();
      end else begin
        if (sl_cpha) slave_sample();
        else begin
          s_tx_idx++;
          if (s_tx_idx < 8) miso = sbit(sl_data, sl_lsb, s_tx_idx);
        end
      end
    end
    s_prev = sclk;
  end

  // ---------------- scoreboard: rx_data captured at each done pulse ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_arr[64];
  int got_n = 0, rd_idx = 0, done_cnt = 0, done3_cnt = 0;

  always @(negedge pclk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (got_n < 64) got_arr[got_n] = rx_data;
      got_n++;
    end
    if (done3 === 1'b1) done3_cnt++;
  end

  task automatic sb_drain();
    while (rd_idx < got_n) begin
      if (exp_q.size() == 0) check("done_without_expectation", exp_q.size(), 1);
      else check("rx_data_at_done", got_arr[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic pol, input logic pha, input logic lsb, input logic lb,
                         input logic [7:0] div, input logic [1:0] sel, input logic [7:0] tx);
    cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; ss_sel = sel; tx_data = tx;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loopback = lb;
`else
    if (lb) $display("note: loopback requested without loopback build");
`endif
  endtask

  task automatic arm_slave(input logic pha, input logic lsb, input logic [7:0] d, input int gap);
    sl_cpha = pha; sl_lsb = lsb; sl_data = d; sl_gap = gap; sl_t0 = cyc;
    sl_active = 1'b1; sl_gen++;
  endtask

  // Waits (bounded) for done; returns the cycle number relative to t0, or -1.
  task automatic wait_done(input int t0, output int at, output int ss_bad, input logic [3:0] exp_ss);
    at = -1; ss_bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1) begin
        at = cyc - t0;
        break;
      end
      if (ss_n !== exp_ss || busy !== 1'b1) ss_bad++;
      @(negedge pclk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       cpol, cpha, lsb, lb;
    logic [7:0] div;
    logic [1:0] ss;
    logic [7:0] tx, slv, exp_rx;
    logic [3:0] exp_ss;
    int         exp_done;
  } vec_t;

  vec_t vec[5];

  task automatic run_vector(input vec_t v, input int idx);
    int t0, at, ss_bad;
    logic first;
    first = v.lsb ? v.tx[0] : v.tx[7];
    @(negedge pclk);
    set_cfg(v.cpol, v.cpha, v.lsb, v.lb, v.div, v.ss, v.tx);
    @(negedge pclk);
    arm_slave(v.cpha, v.lsb, v.slv, int'(v.div) + 1);
    exp_q.push_back(v.exp_rx);
    start = 1'b1; t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    check($sformatf("v%0d_busy_cycle1", idx), busy, 1'b1);
    check($sformatf("v%0d_mosi_first", idx), mosi, first);
    check($sformatf("v%0d_sclk_setup", idx), sclk, v.cpol);
    wait_done(t0, at, ss_bad, v.exp_ss);
    check($sformatf("v%0d_done_cycle", idx), at, v.exp_done);
    check($sformatf("v%0d_ss_busy_during", idx), ss_bad, 0);
    check($sformatf("v%0d_busy_at_done", idx), busy, 1'b0);
    check($sformatf("v%0d_ss_released", idx), ss_n, 4'hF);
    check($sformatf("v%0d_sclk_idle", idx), sclk, v.cpol);
    sl_active = 1'b0;
    check($sformatf("v%0d_slave_rx", idx), s_rx, v.tx);
    check($sformatf("v%0d_slave_first_bit", idx), s_first_bit, first);
    check($sformatf("v%0d_edge_count", idx), s_edges, 16);
    check($sformatf("v%0d_first_edge_cycle", idx), s_first_edge, int'(v.div) + 2);
    check($sformatf("v%0d_edge_spacing", idx), s_bad_gap, 0);
    @(negedge pclk);
    sb_drain();
  endtask

  // ---------------- main test ----------------
  initial begin
    int t0, at, ss_bad, dc0;
    preset_n = 1'b0; start = 1'b0; start3 = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h00);

    //           cpol  cpha  lsb   lb    div    ss    tx     slv    exp_rx exp_ss   done
`ifdef SPI_SHIFT_LOOPBACK_EN
    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 8'hA5, 8'h00, 8'hA5, 4'b1111, 18};
`else
    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'hA5, 8'hA5, 4'b1110, 18};
`endif
    vec[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 2'd2, 8'hC3, 8'h3C, 8'h3C, 4'b1011, 72};
    vec[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 2'd1, 8'h01, 8'h80, 8'h80, 4'b1101, 36};
    vec[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 2'd3, 8'h5A, 8'h96, 8'h96, 4'b0111, 54};
    vec[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 8'h3B, 8'hE4, 8'hE4, 4'b1110, 18};

    // Reset values
    repeat (3) @(negedge pclk);
    check("rst_ss_n", ss_n, 4'hF);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_state", state_dbg, 2'd0);
    preset_n = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 5; i++) run_vector(vec[i], i);

    // Start while busy is ignored; start in the done cycle chains immediately.
    dc0 = done_cnt;
    @(negedge pclk);
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h6E);
    @(negedge pclk);
    arm_slave(1'b0, 1'b0, 8'h2D, 1);
    exp_q.push_back(8'h2D);
    start = 1'b1; t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    while (cyc - t0 < 5) @(negedge pclk);
    tx_data = 8'hFF; start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    wait_done(t0, at, ss_bad, 4'b1110);
    check("b2b_first_done_cycle", at, 18);
    check("b2b_slave_rx_first", s_rx, 8'h6E);
    arm_slave(1'b0, 1'b0, 8'hB4, 1);
    exp_q.push_back(8'hB4);
    tx_data = 8'h93; start = 1'b1; t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    check("b2b_busy_next_cycle", busy, 1'b1);
    check("b2b_mosi_next_cycle", mosi, 1'b1);
    wait_done(t0, at, ss_bad, 4'b1110);
    check("b2b_second_done_cycle", at, 18);
    sl_active = 1'b0;
    check("b2b_slave_rx_second", s_rx, 8'h93);
    repeat (40) @(negedge pclk);
    check("b2b_done_pulses", done_cnt - dc0, 2);
    sb_drain();

    // Reset in the middle of a transaction aborts without done.
    dc0 = done_cnt;
    set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1, 8'h77);
    @(negedge pclk);
    start = 1'b1; t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    while (cyc - t0 < 7) @(negedge pclk);
    check("mid_busy_before_reset", busy, 1'b1);
    preset_n = 1'b0;
    @(negedge pclk);
    check("mid_rst_ss_n", ss_n, 4'hF);
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_mosi", mosi, 1'b0);
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (40) @(negedge pclk);
    check("mid_rst_no_done", done_cnt - dc0, 0);

    // NUM_SS=3 with ss_sel=3: nobody selected, transaction still completes.
    dc0 = done3_cnt;
    sl_idle_miso = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd3, 8'h42);
    repeat (2) @(negedge pclk);
    start3 = 1'b1; t0 = cyc;
    @(negedge pclk);
    start3 = 1'b0;
    check("ss3_busy_cycle1", busy3, 1'b1);
    check("ss3_mosi_cycle1", mosi3, 1'b0);
    at = -1; ss_bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done3 === 1'b1) begin
        at = cyc - t0;
        break;
      end
      if (ss3 !== 3'b111) ss_bad++;
      @(negedge pclk);
    end
    check("ss3_done_cycle", at, 36);
    check("ss3_no_select", ss_bad, 0);
    check("ss3_ss_at_done", ss3, 3'b111);
    check("ss3_rx_data", rx3, 8'hFF);
    repeat (3) @(negedge pclk);
    check("ss3_done_pulses", done3_cnt - dc0, 1);
    check("ss3_idle_state", state3, 2'd0);
    check("ss3_sclk_idle", sclk3, 1'b0);

    sb_drain();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
